multicycle_control_unit: RTL

//  Moore-FSM control unit for the multicycle RV32I datapath; successor to the single-cycle control unit.

---
 rtl/mc_ctrl_pkg.sv | 82 ++++++++
 rtl/alu_decoder.sv | 47 ++++
 rtl/multicycle_control_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle RV32I control unit:
//   - FSM state encodings (4-bit, FETCH..TRAP)
//   - RV32I opcodes handled by the control unit
//   - ALUOp, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and ALUControl encodings
//   - imm_src_of(): opcode -> immediate format select
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // FSM state enumeration, kept as plain 4-bit constants so state_o is a
    // stable, tool-independent debug encoding.
    typedef logic [3:0] mc_state_t;

    localparam mc_state_t ST_FETCH    = 4'd0;
    localparam mc_state_t ST_DECODE   = 4'd1;
    localparam mc_state_t ST_MEMADR   = 4'd2;
    localparam mc_state_t ST_MEMREAD  = 4'd3;
    localparam mc_state_t ST_MEMWB    = 4'd4;
    localparam mc_state_t ST_MEMWRITE = 4'd5;
    localparam mc_state_t ST_EXECR    = 4'd6;
    localparam mc_state_t ST_EXECI    = 4'd7;
    localparam mc_state_t ST_ALUWB    = 4'd8;
    localparam mc_state_t ST_JAL      = 4'd9;
    localparam mc_state_t ST_BEQ      = 4'd10;
    localparam mc_state_t ST_TRAP     = 4'd11;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // ALUOp
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALUControl codes produced by alu_decoder
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format for the extend unit; purely a function of the opcode.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_LW, OP_ITYPE: imm = IMM_I;
            OP_SW:           imm = IMM_S;
            OP_BEQ:          imm = IMM_B;
            OP_JAL:          imm = IMM_J;
            default:         imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Translates ALUOp plus instruction fields into the ALU operation code.
// Ports:
//   alu_op_i      ALUOp: 00 add, 01 sub, 10 decode funct fields
//   op5_i         instr[5] (distinguishes R-type from I-type ALU ops)
//   funct3_i      instr[14:12]
//   funct7b5_i    instr[30]
//   alu_control_o ALU operation (add 000, sub 001, and 010, or 011, slt 101)
// -----------------------------------------------------------------------------
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic       op5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    // Fixed add/sub for address and branch work, funct decode for ALU ops
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000: begin
                        // Only R-type uses instr[30] as sub; for addi it is an immediate bit
                        if (op5_i && funct7b5_i) begin
                            alu_control_o = ALU_SUB;
                        end else begin
                            alu_control_o = ALU_ADD;
                        end
                    end
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Moore-FSM control for the multicycle RV32I datapath (lw, sw, R/I ALU, beq,
// jal). Sequences FETCH/DECODE/EXECUTE/MEM/WB and stalls FETCH, MEMREAD and
// MEMWRITE on the unified memory's mem_ready handshake.
//
// Build option: define MC_ILLEGAL_TRAP_EN to send unknown opcodes to a TRAP
// state (sticky illegal_o, exit only via reset). Without it an unknown opcode
// completes as a NOP and illegal_o is tied low.
//
// Parameters:
//   ALU_CTRL_W    width of ALUControl (>= 3)
//   IMM_SRC_W     width of ImmSrc (>= 2)
//   MEM_HANDSHAKE 1: wait for mem_ready, 0: mem_ready treated as always 1
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   op, funct3, funct7b5        instruction fields from the IR
//   zero                        ALU zero flag (beq)
//   mem_ready                   memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite,
//   IRWrite, RegWrite           datapath enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB mux selects
//   ImmSrc, ALUControl          extend format and ALU operation
//   illegal_o                   sticky illegal-opcode flag
//   state_o                     current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W    = 3,
    parameter int IMM_SRC_W     = 2,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [IMM_SRC_W-1:0]  ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  illegal_o,
    output logic [3:0]            state_o
);

    mc_state_t   state_q;
    mc_state_t   state_d;
    logic        mem_ok_s;
    logic        pc_update_s;
    logic        branch_s;
    logic        adr_src_s;
    logic        mem_write_s;
    logic        ir_write_s;
    logic        reg_write_s;
    logic [1:0]  result_src_s;
    logic [1:0]  alu_src_a_s;
    logic [1:0]  alu_src_b_s;
    logic [1:0]  alu_op_s;
    logic [2:0]  alu_ctrl_s;

    assign mem_ok_s = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // State register; the async reset lands in FETCH from any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ok_s) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXECR;
                    OP_ITYPE:     state_d = ST_EXECI;
                    OP_JAL:       state_d = ST_JAL;
                    OP_BEQ:       state_d = ST_BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = ST_TRAP;
`else
                    // PC was already advanced in FETCH, so this retires as a NOP
                    default:      state_d = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR: begin
                if (op == OP_LW) begin
                    state_d = ST_MEMREAD;
                end else begin
                    state_d = ST_MEMWRITE;
                end
            end
            ST_MEMREAD: begin
                if (mem_ok_s) begin
                    state_d = ST_MEMWB;
                end else begin
                    state_d = ST_MEMREAD;
                end
            end
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: begin
                if (mem_ok_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEMWRITE;
                end
            end
            ST_EXECR:    state_d = ST_ALUWB;
            ST_EXECI:    state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_JAL:      state_d = ST_ALUWB;
            ST_BEQ:      state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Moore output decode; only FETCH's enables look at mem_ready
    always_comb begin
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RS2;
        alu_op_s     = ALUOP_ADD;
        case (state_q)
            ST_FETCH: begin
                ir_write_s   = mem_ok_s;
                pc_update_s  = mem_ok_s;
                alu_src_a_s  = SRCA_PC;
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALURESULT;
            end
            ST_DECODE: begin
                // Branch target OldPC + imm is precomputed here into ALUOut
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
            end
            ST_MEMADR: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
            end
            ST_MEMREAD: begin
                adr_src_s    = 1'b1;
                result_src_s = RES_ALUOUT;
            end
            ST_MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
            end
            ST_MEMWRITE: begin
                // Held high for the whole wait so the memory sees a stable request
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                result_src_s = RES_ALUOUT;
            end
            ST_EXECR: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_RS2;
                alu_op_s    = ALUOP_FUNCT;
            end
            ST_EXECI: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                result_src_s = RES_ALUOUT;
                reg_write_s  = 1'b1;
            end
            ST_JAL: begin
                // ALU forms OldPC+4 (link value); PC loads the target from ALUOut
                alu_src_a_s  = SRCA_OLDPC;
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALUOUT;
                pc_update_s  = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a_s  = SRCA_RS1;
                alu_src_b_s  = SRCB_RS2;
                alu_op_s     = ALUOP_SUB;
                result_src_s = RES_ALUOUT;
                branch_s     = 1'b1;
            end
            ST_TRAP: begin
                pc_update_s = 1'b0;
            end
            default: begin
                pc_update_s = 1'b0;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op_s),
        .op5_i         (op[5]),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_ctrl_s)
    );

    // Enables are gated with rst_n so nothing writes while reset is held
    assign PCWrite    = rst_n & (pc_update_s | (branch_s & zero));
    assign IRWrite    = rst_n & ir_write_s;
    assign MemWrite   = rst_n & mem_write_s;
    assign RegWrite   = rst_n & reg_write_s;
    assign AdrSrc     = adr_src_s;
    assign ResultSrc  = result_src_s;
    assign ALUSrcA    = alu_src_a_s;
    assign ALUSrcB    = alu_src_b_s;
    assign ImmSrc     = IMM_SRC_W'(imm_src_of(op));
    assign ALUControl = ALU_CTRL_W'(alu_ctrl_s);
    assign state_o    = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q;
    logic illegal_d;

    // Flag sets on entry to TRAP and stays set until reset
    always_comb begin
        illegal_d = illegal_q | (state_d == ST_TRAP);
    end

    // Sticky illegal-opcode register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

endmodule
